// File: rtl/ssd_pkg.sv
// ============================================================================
// Module  : ssd_pkg
// Brief   : Shared types and the 7-segment encoder for the dual-digit SSD mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ssd_pkg;

    typedef enum logic [0:0] {
        FILL_L = 1'b0,
        FILL_R = 1'b1
    } fill_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg_enc(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ssd_refresh_timer.sv
// ============================================================================
// Module  : ssd_refresh_timer
// Brief   : Half-frame counter; pulses toggle on terminal count and flips chip_sel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_refresh_timer #(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int REFRESH_HZ = 100
) (
    input  logic clk,
    input  logic rst,
    output logic toggle,
    output logic chip_sel
);

    localparam int HALF  = CLK_FREQ / (2 * REFRESH_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_TERMINAL = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    generate
        if (HALF < 2) begin : g_half_check
            $error("ssd_refresh_timer: HALF = CLK_FREQ/(2*REFRESH_HZ) must be >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chip_sel_q, chip_sel_d;

    always_comb begin
        toggle     = (cnt_q == CNT_TERMINAL);
        cnt_d      = toggle ? '0 : cnt_q + CNT_ONE;
        chip_sel_d = chip_sel_q ^ toggle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            chip_sel_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            chip_sel_q <= chip_sel_d;
        end
    end

    assign chip_sel = chip_sel_q;

endmodule

`default_nettype wire

// File: rtl/ssd_dual_digit_mux.sv
// ============================================================================
// Module  : ssd_dual_digit_mux
// Brief   : Latches keypad digits into a left/right pair and time-multiplexes
//           them onto the dual-digit SSD. Option macro: SSD_BLANK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_dual_digit_mux
    import ssd_pkg::*;
#(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int REFRESH_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_pressed,
    input  logic [3:0] key_code,
    input  logic       clr,
    output logic [6:0] seg,
    output logic       chip_sel,
    output logic [3:0] left_digit,
    output logic [3:0] right_digit,
    output logic       next_is_right
);

`ifdef SSD_BLANK_EN
    localparam logic [6:0] SEG_RESET = SEG_BLANK;
`else
    localparam logic [6:0] SEG_RESET = 7'b0111111;
`endif

    logic        refresh_toggle;
    logic        chip_sel_cur;

    logic        key_q, key_d;
    fill_state_t state_q, state_d;
    logic [3:0]  left_q, left_d;
    logic [3:0]  right_q, right_d;
    logic [6:0]  seg_q, seg_d;
    logic        key_event;
    logic        show_left;
    logic [6:0]  disp_left, disp_right;

    ssd_refresh_timer #(
        .CLK_FREQ   (CLK_FREQ),
        .REFRESH_HZ (REFRESH_HZ)
    ) u_refresh_timer (
        .clk      (clk),
        .rst      (rst),
        .toggle   (refresh_toggle),
        .chip_sel (chip_sel_cur)
    );

`ifdef SSD_BLANK_EN
    logic left_vld_q, left_vld_d;
    logic right_vld_q, right_vld_d;

    always_comb begin
        left_vld_d  = left_vld_q;
        right_vld_d = right_vld_q;
        if (clr) begin
            left_vld_d  = 1'b0;
            right_vld_d = 1'b0;
        end else if (key_event) begin
            if (state_q == FILL_L) left_vld_d  = 1'b1;
            else                   right_vld_d = 1'b1;
        end
        disp_left  = left_vld_q  ? seg_enc(left_q)  : SEG_BLANK;
        disp_right = right_vld_q ? seg_enc(right_q) : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_vld_q  <= 1'b0;
            right_vld_q <= 1'b0;
        end else begin
            left_vld_q  <= left_vld_d;
            right_vld_q <= right_vld_d;
        end
    end
`else
    always_comb begin
        disp_left  = seg_enc(left_q);
        disp_right = seg_enc(right_q);
    end
`endif

    always_comb begin
        key_d     = key_pressed;
        key_event = key_pressed & ~key_q;
        state_d   = state_q;
        left_d    = left_q;
        right_d   = right_q;
        // clr has priority: a key edge in the same cycle is dropped.
        if (clr) begin
            state_d = FILL_L;
            left_d  = 4'h0;
            right_d = 4'h0;
        end else if (key_event) begin
            if (state_q == FILL_L) begin
                left_d  = key_code;
                state_d = FILL_R;
            end else begin
                right_d = key_code;
                state_d = FILL_L;
            end
        end
        // Load the side that will be selected after this edge, so seg and chip_sel move together.
        show_left = chip_sel_cur ^ refresh_toggle;
        seg_d     = show_left ? disp_left : disp_right;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= 1'b0;
            state_q <= FILL_L;
            left_q  <= 4'h0;
            right_q <= 4'h0;
            seg_q   <= SEG_RESET;
        end else begin
            key_q   <= key_d;
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            seg_q   <= seg_d;
        end
    end

    assign seg           = seg_q;
    assign chip_sel      = chip_sel_cur;
    assign left_digit    = left_q;
    assign right_digit   = right_q;
    assign next_is_right = (state_q == FILL_R);

endmodule

`default_nettype wire

// File: tb/tb_ssd_dual_digit_mux.sv
// ============================================================================
// Module  : tb_ssd_dual_digit_mux
// Brief   : Self-checking bench with a cycle scoreboard for ssd_dual_digit_mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssd_dual_digit_mux;

    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_pressed;
    logic [3:0] key_code;
    logic       clr;
    logic [6:0] seg;
    logic       chip_sel;
    logic [3:0] left_digit;
    logic [3:0] right_digit;
    logic       next_is_right;

    ssd_dual_digit_mux #(
        .CLK_FREQ   (1000),
        .REFRESH_HZ (50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_pressed   (key_pressed),
        .key_code      (key_code),
        .clr           (clr),
        .seg           (seg),
        .chip_sel      (chip_sel),
        .left_digit    (left_digit),
        .right_digit   (right_digit),
        .next_is_right (next_is_right)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       cs;
        logic [3:0] l;
        logic [3:0] r;
        logic       nir;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [6:0] enc_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

`ifdef SSD_BLANK_EN
    localparam logic [6:0] EXP_SEG_RST = 7'h00;
    localparam logic [6:0] EXP_SEG_UNW = 7'h00;
`else
    localparam logic [6:0] EXP_SEG_RST = 7'h3F;
    localparam logic [6:0] EXP_SEG_UNW = 7'h3F;
`endif

    // Reference model state
    int         m_cnt;
    logic       m_cs, m_kq, m_st, m_vl, m_vr;
    logic [3:0] m_l, m_r;
    logic [6:0] m_seg;
    logic [6:0] prev_seg;
    logic       prev_cs;

    function automatic logic [6:0] disp(input logic [3:0] d, input logic v);
`ifdef SSD_BLANK_EN
        return v ? enc_tab[d] : 7'h00;
`else
        return enc_tab[d];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic       r, k, c, ev, tg;
        logic [3:0] code;
        exp_t       e, o;
        r = rst; k = key_pressed; c = clr; code = key_code;
        prev_seg = seg;
        prev_cs  = chip_sel;
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_cs = 1'b0; m_kq = 1'b0; m_st = 1'b0;
            m_l = 4'h0; m_r = 4'h0; m_vl = 1'b0; m_vr = 1'b0;
            m_seg = EXP_SEG_RST;
        end else begin
            ev    = k & ~m_kq;
            m_kq  = k;
            tg    = (m_cnt == HALF - 1);
            m_cnt = tg ? 0 : m_cnt + 1;
            m_cs  = m_cs ^ tg;
            m_seg = m_cs ? disp(m_l, m_vl) : disp(m_r, m_vr);
            if (c) begin
                m_l = 4'h0; m_r = 4'h0; m_vl = 1'b0; m_vr = 1'b0; m_st = 1'b0;
            end else if (ev) begin
                if (!m_st) begin m_l = code; m_vl = 1'b1; m_st = 1'b1; end
                else       begin m_r = code; m_vr = 1'b1; m_st = 1'b0; end
            end
        end
        e = '{seg: m_seg, cs: m_cs, l: m_l, r: m_r, nir: m_st};
        exp_q.push_back(e);
        #1;
        o = exp_q.pop_front();
        check("sb_seg",      {25'b0, seg},           {25'b0, o.seg});
        check("sb_chip_sel", {31'b0, chip_sel},      {31'b0, o.cs});
        check("sb_left",     {28'b0, left_digit},    {28'b0, o.l});
        check("sb_right",    {28'b0, right_digit},   {28'b0, o.r});
        check("sb_nir",      {31'b0, next_is_right}, {31'b0, o.nir});
    endtask

    task automatic press(input logic [3:0] code);
        key_code = code; key_pressed = 1'b1;
        repeat (3) tick();
        key_pressed = 1'b0;
        repeat (2) tick();
    endtask

    // Cycles from now until chip_sel next changes (bounded).
    task automatic cycles_to_toggle(output int n);
        logic start;
        start = chip_sel;
        n = 0;
        while (chip_sel === start && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, last_edge, edges;
        rst = 1'b1; key_pressed = 1'b0; key_code = 4'h0; clr = 1'b0;

        // 1. reset
        repeat (3) tick();
        check("rst_seg",      {25'b0, seg},      {25'b0, EXP_SEG_RST});
        check("rst_chip_sel", {31'b0, chip_sel}, 32'd0);
        check("rst_left",     {28'b0, left_digit}, 32'd0);
        rst = 1'b0;
        cycles_to_toggle(n);
        check("first_toggle_cycles", n, 10);

        // 2. held key gives a single write
        key_code = 4'h5; key_pressed = 1'b1;
        repeat (20) tick();
        key_pressed = 1'b0;
        tick();
        check("held_left", {28'b0, left_digit},    32'h5);
        check("held_right", {28'b0, right_digit},  32'h0);
        check("held_nir",  {31'b0, next_is_right}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (chip_sel) check("held_seg_left",  {25'b0, seg}, {25'b0, 7'h6D});
            else          check("held_seg_right", {25'b0, seg}, {25'b0, EXP_SEG_UNW});
        end

        // 3. wrap-around
        clr = 1'b1; tick(); clr = 1'b0; tick();
        press(4'h5); press(4'h9); press(4'h3);
        check("wrap_left",  {28'b0, left_digit},    32'h3);
        check("wrap_right", {28'b0, right_digit},   32'h9);
        check("wrap_nir",   {31'b0, next_is_right}, 32'd1);

        // 4. clr coincident with key-7 edge
        key_code = 4'h7; key_pressed = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (3) tick();
        key_pressed = 1'b0;
        tick();
        check("clr_left",  {28'b0, left_digit},    32'h0);
        check("clr_right", {28'b0, right_digit},   32'h0);
        check("clr_nir",   {31'b0, next_is_right}, 32'd0);

        // 5. free-run with distinct digits
        press(4'hA); press(4'h2);
        last_edge = -1; edges = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (chip_sel !== prev_cs) begin
                if (last_edge >= 0) check("half_period", i - last_edge, HALF);
                last_edge = i;
                edges++;
            end
            check("seg_chg_with_cs", {31'b0, (seg !== prev_seg) && (chip_sel === prev_cs)}, 32'd0);
        end
        check("edges_in_100", edges, 10);

        // 6. reset mid-frame at count 6 while left side shown
        n = 0;
        while (!(m_cnt == 6 && m_cs) && n < 60) begin tick(); n++; end
        check("found_cnt6", {31'b0, (m_cnt == 6 && m_cs)}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_chip_sel", {31'b0, chip_sel},  32'd0);
        check("mid_rst_left",     {28'b0, left_digit},  32'h0);
        check("mid_rst_right",    {28'b0, right_digit}, 32'h0);
        rst = 1'b0;
        cycles_to_toggle(n);
        check("mid_rst_toggle_cycles", n, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
